// File: rtl/nx_link_buffer.sv
// Registered elastic link buffer between adjacent mesh nodes; no fall-through, ready depends on state only.
// Optional statistics counters are built when NX_LINK_STATS_EN is defined; otherwise they read 0.
module nx_link_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_inbound_data,
  input  logic                     i_inbound_valid,
  output logic                     o_inbound_ready,
  output logic [WIDTH-1:0]         o_outbound_data,
  output logic                     o_outbound_valid,
  input  logic                     i_outbound_ready,
  output logic                     o_idle,
  output logic [$clog2(DEPTH):0]   o_level,
  input  logic                     i_stat_clear,
  output logic [31:0]              o_stat_msgs,
  output logic [31:0]              o_stat_stalls
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;
  logic             w_stall;

  // Handshake: a transfer happens on a side only in a cycle where valid and ready are both 1;
  // the sender holds data stable while valid && !ready, and valid is never withdrawn without a transfer.
  assign o_inbound_ready  = (r_level != LW'(DEPTH));
  assign o_outbound_valid = (r_level != '0);
  assign o_outbound_data  = r_mem[r_rd_ptr];
  assign o_idle           = (r_level == '0);
  assign o_level          = r_level;

  assign w_push  = i_inbound_valid && o_inbound_ready;
  assign w_pop   = o_outbound_valid && i_outbound_ready;
  assign w_stall = o_outbound_valid && !i_outbound_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_inbound_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

`ifdef NX_LINK_STATS_EN
  logic [31:0] r_stat_msgs;
  logic [31:0] r_stat_stalls;

  // Message count wraps; stall count saturates so long stalls never look short.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_stat_clear) begin
      r_stat_msgs   <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_pop) begin
        r_stat_msgs <= r_stat_msgs + 32'd1;
      end
      if (w_stall && (r_stat_stalls != 32'hFFFF_FFFF)) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign o_stat_msgs   = r_stat_msgs;
  assign o_stat_stalls = r_stat_stalls;
`else
  logic w_unused_stats;
  assign w_unused_stats = i_stat_clear ^ w_stall;
  assign o_stat_msgs    = '0;
  assign o_stat_stalls  = '0;
`endif

endmodule

// File: doc/nx_link_buffer.md
# nx_link_buffer

Registered, elastic buffer inserted on each link between adjacent `nx_node` instances, and between edge nodes and the mesh boundary. It accepts messages from one node's outbound port and presents them to the neighbouring node's inbound port. It breaks the combinational ready/valid path between the two nodes' distributor and arbiter, and absorbs short back-pressure bursts. It also reports emptiness into the mesh idle chain.

## Interface
Parameters:
- `WIDTH`, default `MESSAGE_WIDTH`: message width in bits.
- `DEPTH`, default `2`: number of entries. Must be a power of two, minimum 2.

Ports:
- `i_clk`, input, 1: clock. Single clock domain.
- `i_rst`, input, 1: reset. Synchronous, active-low: state clears on a rising edge of `i_clk` while `i_rst` is 0.
- `i_inbound_data`, input, `WIDTH`: message from the upstream node's `o_outbound_data[n]`.
- `i_inbound_valid`, input, 1: upstream message valid.
- `o_inbound_ready`, output, 1: buffer can accept a message this cycle.
- `o_outbound_data`, output, `WIDTH`: head message, driven to the downstream node's `i_inbound_data[m]`.
- `o_outbound_valid`, output, 1: head message valid.
- `i_outbound_ready`, input, 1: downstream node accepts the head message.
- `o_idle`, output, 1: buffer is empty.
- `o_level`, output, `$clog2(DEPTH)+1`: current occupancy.
- `i_stat_clear`, input, 1: synchronous clear of the statistics counters.
- `o_stat_msgs`, output, 32: count of messages popped.
- `o_stat_stalls`, output, 32: count of back-pressure cycles.

## Operation
- Storage: `DEPTH`-entry array, write pointer, read pointer, and occupancy count. Each pointer is `$clog2(DEPTH)` bits and wraps naturally from `DEPTH-1` to 0.
- Push when `i_inbound_valid && o_inbound_ready`: write to `array[wr_ptr]`, then increment `wr_ptr`.
- Pop when `o_outbound_valid && i_outbound_ready`: increment `rd_ptr`.
- Occupancy update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- `o_inbound_ready = (level != DEPTH)`. It depends on registered state only, never on `i_outbound_ready`.
- When full, a same-cycle pop does not enable a push. There is no fall-through path.
- `o_outbound_valid = (level != 0)`.
- `o_outbound_data = array[rd_ptr]`. It is stable while `o_outbound_valid && !i_outbound_ready`.
- `o_idle = (level == 0)`. The downstream node ANDs this into its own local idle term.
- Messages are delivered strictly in order. Contents are never modified, inspected or dropped.
- Handshake rules:
  - Upstream must hold data stable while valid and not ready.
  - The buffer never retracts `o_outbound_valid` without a pop.
- Reset values:
  - pointers 0, level 0
  - all array entries 0, so `o_outbound_data` = 0
  - `o_outbound_valid` 0, `o_inbound_ready` 1, `o_idle` 1, `o_level` 0
  - statistics counters 0
- Reset mid-operation: all stored messages are discarded. No pop or push takes effect in the reset cycle, regardless of valid/ready.

## Timing
- Latency: a message pushed in cycle N appears on `o_outbound_valid`/`o_outbound_data` in cycle N+1.
- Throughput: one message per cycle sustained when downstream is always ready (`DEPTH` ≥ 2).
- `o_inbound_ready` deasserts the cycle after the push that fills the buffer. It reasserts the cycle after the first pop from full.
- `o_level` and `o_idle` reflect post-edge state, with no combinational path from inputs.

## Configuration
- Macro: `NX_LINK_STATS_EN`.
- When defined:
  - `o_stat_msgs` increments by 1 on every pop and wraps modulo 2^32.
  - `o_stat_stalls` increments on every cycle with `o_outbound_valid && !i_outbound_ready`, and saturates at `32'hFFFF_FFFF`.
  - `i_stat_clear` zeros both counters next edge. A clear coincident with an increment yields 0.
- When not defined: the counter logic is absent, both outputs are tied to 0, and `i_stat_clear` is ignored. Ports remain, so instantiation is unchanged.

## Test plan
- Reset: hold `i_rst`=0 for 3 cycles with `i_inbound_valid`=1. Required: no push, `o_outbound_valid`=0, `o_inbound_ready`=1, `o_idle`=1, `o_level`=0.
- Streaming: push 0x11, 0x22, 0x33 on consecutive cycles with `i_outbound_ready`=1. Required: outputs appear one cycle later, in order, `o_level` never exceeds 1, and the `o_stat_msgs` final value is 3.
- Full/back-pressure (`DEPTH`=2): with `i_outbound_ready`=0, push 0xA, 0xB, then offer 0xC. Required: `o_inbound_ready`=0 after the second push, 0xC is not accepted, `o_outbound_data` holds 0xA, and `o_stat_stalls` counts every waiting cycle.
- Simultaneous pop at full: with the buffer full and `i_outbound_ready`=1 while 0xC is offered, 0xC is not taken that cycle. Required: it is accepted the following cycle, and the output order is 0xA, 0xB, 0xC.
- Wrap-around: push/pop 2×`DEPTH`+1 distinct messages with random ready. Required: order is preserved across pointer wrap and `o_idle`=1 at the end.
- Mid-operation reset and stats: reset with 2 entries held. Required: `o_level`=0 and the old data is never emitted. Assert `i_stat_clear` during a pop; required: `o_stat_msgs`=0 next cycle. Without `NX_LINK_STATS_EN`, both counters read 0 throughout.
